// File: rtl/xbuf_tbm_writer_if.sv
// Bus bundle between the xfer-buffer TBM writer and its environment:
// controller command/status, xfer-buffer read port and TBM write port.
// Optional macro XBUF_TBM_CHECKSUM_EN adds the running checksum output.
interface xbuf_tbm_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BUF_AW = 10,
  parameter int CNT_W  = 11
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              buf_rd_en;
  logic [BUF_AW-1:0] buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              xfer_complete;
  logic [CNT_W-1:0]  words_done;
`ifdef XBUF_TBM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  // Writer side
  modport master (
`ifdef XBUF_TBM_CHECKSUM_EN
    output checksum,
`endif
    input  start, start_addr, word_count, buf_rd_data, mem_ready,
    output busy, buf_rd_en, buf_rd_addr, mem_wr_en, mem_addr, mem_wdata,
           xfer_complete, words_done
  );

  // Controller / buffer / TBM side
  modport slave (
`ifdef XBUF_TBM_CHECKSUM_EN
    input  checksum,
`endif
    output start, start_addr, word_count, buf_rd_data, mem_ready,
    input  busy, buf_rd_en, buf_rd_addr, mem_wr_en, mem_addr, mem_wdata,
           xfer_complete, words_done
  );
endinterface

// File: rtl/xbuf_tbm_writer.sv
// Drains a block of words from the xfer buffer RX array into TBM.
// Per word: RD (issue buffer read) -> LAT (capture data, raise write)
// -> WR (hold until TBM accepts). DONE pulses xfer_complete.
// Every output comes straight from a register.
// Optional macro XBUF_TBM_CHECKSUM_EN adds a modular sum of written words.
module xbuf_tbm_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BUF_AW = 10,
  parameter int CNT_W  = 11
) (
  input logic         clock_fpga,
  input logic         reset,
  xbuf_tbm_writer_if.master bus
);
  // Largest transfer is one full buffer
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** BUF_AW);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic [BUF_AW-1:0] r_rd_addr, w_rd_addr_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_xc, w_xc_nxt;
  logic [CNT_W-1:0]  r_words, w_words_nxt;
  logic [CNT_W-1:0]  w_idx_inc;
`ifdef XBUF_TBM_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum, w_csum_nxt;
`endif

  assign w_idx_inc = r_idx + CNT_W'(1);

  // Next state and next register values for every output
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_base_nxt     = r_base;
    w_rd_en_nxt    = 1'b0;
    w_rd_addr_nxt  = r_rd_addr;
    w_wr_en_nxt    = r_wr_en;
    w_mem_addr_nxt = r_mem_addr;
    w_wdata_nxt    = r_wdata;
    w_xc_nxt       = 1'b0;
    w_words_nxt    = r_words;
`ifdef XBUF_TBM_CHECKSUM_EN
    w_csum_nxt     = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_words_nxt = '0;
`ifdef XBUF_TBM_CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
          if (bus.word_count != '0) begin
            w_cnt_nxt     = (bus.word_count > MAX_CNT) ? MAX_CNT : bus.word_count;
            w_base_nxt    = bus.start_addr;
            w_idx_nxt     = '0;
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = '0;
            w_state_nxt   = S_RD;
          end else begin
            // Empty transfer completes immediately
            w_xc_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RD: begin
        w_state_nxt = S_LAT;
      end
      S_LAT: begin
        // Buffer data is valid now, one cycle after the read strobe
        w_wdata_nxt    = bus.buf_rd_data;
        w_mem_addr_nxt = r_base + ADDR_W'(r_idx);
        w_wr_en_nxt    = 1'b1;
        w_state_nxt    = S_WR;
      end
      S_WR: begin
        if (bus.mem_ready) begin
          w_wr_en_nxt = 1'b0;
          w_idx_nxt   = w_idx_inc;
          w_words_nxt = r_words + CNT_W'(1);
`ifdef XBUF_TBM_CHECKSUM_EN
          w_csum_nxt  = r_csum + r_wdata;
`endif
          if (w_idx_inc == r_cnt) begin
            w_xc_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            // idx+1 < count <= 2^BUF_AW, so the truncation is lossless
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = w_idx_inc[BUF_AW-1:0];
            w_state_nxt   = S_RD;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_base     <= '0;
      r_busy     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_xc       <= 1'b0;
      r_words    <= '0;
`ifdef XBUF_TBM_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_base     <= w_base_nxt;
      r_busy     <= w_busy_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_xc       <= w_xc_nxt;
      r_words    <= w_words_nxt;
`ifdef XBUF_TBM_CHECKSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

  assign bus.busy          = r_busy;
  assign bus.buf_rd_en     = r_rd_en;
  assign bus.buf_rd_addr   = r_rd_addr;
  assign bus.mem_wr_en     = r_wr_en;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.xfer_complete = r_xc;
  assign bus.words_done    = r_words;
`ifdef XBUF_TBM_CHECKSUM_EN
  assign bus.checksum      = r_csum;
`endif
endmodule

// File: tb/tb_xbuf_tbm_writer.sv
// Bench for xbuf_tbm_writer: table of transfers plus a hand-written
// mid-transfer reset sequence. TBM writes are checked against a queue
// of expected {addr,data} filled when each transfer is started.
module tb_xbuf_tbm_writer;
  localparam int DW = 32, AW = 32, BAW = 10, CW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xbuf_tbm_writer_if #(.DATA_W(DW), .ADDR_W(AW), .BUF_AW(BAW), .CNT_W(CW)) bus();
  xbuf_tbm_writer #(.DATA_W(DW), .ADDR_W(AW), .BUF_AW(BAW), .CNT_W(CW)) dut (
    .clock_fpga(clk), .reset(rst), .bus(bus)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [31:0] base; int count; int stall_word; int stall_len;
    int repulse; int exp_n; int exp_lat;
  } vec_t;

  wr_t         sbq[$];
  logic [31:0] bufm [0:1023];
  int checks = 0, errors = 0;
  int wr_seen = 0, xc_seen = 0, rd_seen = 0;
  logic        stall_pend = 1'b0;
  logic [31:0] hold_addr, hold_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Buffer RX array model: data one cycle after the read strobe
  always @(posedge clk) if (bus.buf_rd_en) bus.buf_rd_data <= bufm[bus.buf_rd_addr];

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    wr_t e;
    if (bus.buf_rd_en) rd_seen <= rd_seen + 1;
    if (bus.xfer_complete) xc_seen <= xc_seen + 1;
    if (stall_pend) begin
      chk("stall_wr_en_held", 64'(bus.mem_wr_en), 64'd1);
      chk("stall_addr_stable", 64'(bus.mem_addr), 64'(hold_addr));
      chk("stall_data_stable", 64'(bus.mem_wdata), 64'(hold_data));
    end
    if (bus.mem_wr_en && bus.mem_ready) begin
      wr_seen <= wr_seen + 1;
      if (sbq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
    stall_pend <= bus.mem_wr_en && !bus.mem_ready;
    hold_addr  <= bus.mem_addr;
    hold_data  <= bus.mem_wdata;
  end

  task automatic run_vec(input vec_t v);
    int cyc, st, lat, b_wr, b_xc, b_rd;
    logic got;
    logic [31:0] exp_sum;
    exp_sum = '0;
    for (int i = 0; i < v.exp_n; i++) begin
      sbq.push_back('{addr: v.base + 32'(i), data: bufm[i]});
      exp_sum += bufm[i];
    end
    b_wr = wr_seen; b_xc = xc_seen; b_rd = rd_seen;
    bus.start = 1'b1; bus.start_addr = v.base; bus.word_count = CW'(v.count);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; st = 0; got = 1'b0; lat = -1;
    while (!got && cyc <= v.exp_lat + 40) begin
      if (cyc == 1) begin
        chk("busy_first_cycle", 64'(bus.busy), 64'd1);
        chk("rd_en_first_cycle", 64'(bus.buf_rd_en), 64'(v.exp_n != 0));
      end
      if (cyc == 3) chk("wr_en_third_cycle", 64'(bus.mem_wr_en), 64'(v.exp_n != 0));
      if (bus.xfer_complete) begin
        got = 1'b1; lat = cyc;
        chk("words_done", 64'(bus.words_done), 64'(v.exp_n));
`ifdef XBUF_TBM_CHECKSUM_EN
        chk("checksum", 64'(bus.checksum), 64'(exp_sum));
`endif
      end else begin
        if (bus.mem_wr_en && (wr_seen - b_wr) == v.stall_word && st < v.stall_len) begin
          bus.mem_ready = 1'b0; st++;
        end else bus.mem_ready = 1'b1;
        if (cyc == v.repulse) begin
          bus.start = 1'b1; bus.start_addr = 32'h5555_0000; bus.word_count = CW'(7);
        end else bus.start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("complete_latency", 64'(lat), 64'(v.exp_lat));
    bus.start = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("xc_one_cycle", 64'(bus.xfer_complete), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("write_count", 64'(wr_seen - b_wr), 64'(v.exp_n));
    chk("read_count", 64'(rd_seen - b_rd), 64'(v.exp_n));
    chk("xc_count", 64'(xc_seen - b_xc), 64'd1);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_rd_en"}, 64'(bus.buf_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.buf_rd_addr), 64'd0);
    chk({tag, "_wr_en"}, 64'(bus.mem_wr_en), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, "_xc"}, 64'(bus.xfer_complete), 64'd0);
    chk({tag, "_words_done"}, 64'(bus.words_done), 64'd0);
`ifdef XBUF_TBM_CHECKSUM_EN
    chk({tag, "_checksum"}, 64'(bus.checksum), 64'd0);
`endif
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v2;
    int n, b_wr, b_xc;
    //          base           count  stall  len  repulse exp_n lat
    vecs[0] = '{32'h0000_0100,    4,   -1,   0,   0,      4,    13};
    vecs[1] = '{32'h0000_4000, 1024,   -1,   0,   0,   1024,  3073};
    vecs[2] = '{32'h0000_0200,    4,    2,   5,   0,      4,    18};
    vecs[3] = '{32'h0000_0300,    0,   -1,   0,   0,      0,     1};
    vecs[4] = '{32'h0000_8000, 2000,   -1,   0,   0,   1024,  3073};
    vecs[5] = '{32'hFFFF_FFFE,    4,   -1,   0,   5,      4,    13};
    for (int i = 0; i < 1024; i++) bufm[i] = 32'(i);

    rst = 1'b1; bus.start = 1'b0; bus.start_addr = '0; bus.word_count = '0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k]);
`ifdef XBUF_TBM_CHECKSUM_EN
      if (k == 1) chk("checksum_1024", 64'(bus.checksum), 64'h7FE00);
`endif
    end

    // Reset after 10 accepted writes aborts the transfer
    for (int i = 0; i < 100; i++) sbq.push_back('{addr: 32'h2000 + 32'(i), data: bufm[i]});
    b_wr = wr_seen; b_xc = xc_seen;
    bus.start = 1'b1; bus.start_addr = 32'h2000; bus.word_count = CW'(100);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while ((wr_seen - b_wr) < 10 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("ten_writes_before_reset", 64'(wr_seen - b_wr), 64'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    sbq.delete();
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("writes_after_abort", 64'(wr_seen - b_wr), 64'd10);
    chk("no_xc_after_abort", 64'(xc_seen - b_xc), 64'd0);
    chk("idle_after_abort", 64'(bus.busy), 64'd0);

    v2 = '{32'h0000_0010, 2, -1, 0, 0, 2, 7};
    run_vec(v2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
